// File: rtl/ring_seq_monitor.sv
// ring_seq_monitor
// Receive-side checker for a one-hot ring-counter pattern (1->2->4->8->1 forward,
// or the reverse rotation). It samples the ring word, acquires lock in either
// direction, flywheels through isolated glitches, and counts laps and errors.
//
// Ports:
//   clk_2      - clock; all state changes on the rising edge
//   reset      - synchronous, active-high reset
//   din        - sampled ring word (NBITS_RING bits)
//   din_valid  - din is evaluated only when 1
//   clr_counts - synchronous clear of lap_count and err_count (wins over increments)
//   locked     - 1 in LOCKED or SLIP
//   dir        - 0 = forward (rotate-left), 1 = reverse (rotate-right); holds last value
//   err_pulse  - one-cycle pulse per detected error
//   lap_count  - completed laps while locked, saturating
//   err_count  - detected errors, saturating
//   expected   - next expected ring value (0 when not locked)
//   state      - SEARCH=0, ACQUIRE=1, LOCKED=2, SLIP=3
//
// Every output is registered and reflects a din_valid sample one cycle later.
module ring_seq_monitor #(
   parameter int NBITS_RING  = 4,
   parameter int NBITS_CNT   = 8,
   parameter int LOCK_LEN    = 4,
   parameter int UNLOCK_ERRS = 2
) (
   input  logic                  clk_2,
   input  logic                  reset,
   input  logic [NBITS_RING-1:0] din,
   input  logic                  din_valid,
   input  logic                  clr_counts,
   output logic                  locked,
   output logic                  dir,
   output logic                  err_pulse,
   output logic [NBITS_CNT-1:0]  lap_count,
   output logic [NBITS_CNT-1:0]  err_count,
   output logic [NBITS_RING-1:0] expected,
   output logic [1:0]            state
);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;
   localparam logic [1:0] ST_SLIP    = 2'd3;

   localparam int RUN_W  = $clog2(LOCK_LEN + 1);
   localparam int MISS_W = $clog2(UNLOCK_ERRS + 1);
   localparam logic [RUN_W-1:0]     LOCK_LEN_C    = RUN_W'(LOCK_LEN);
   localparam logic [MISS_W-1:0]    UNLOCK_ERRS_C = MISS_W'(UNLOCK_ERRS);
   localparam logic [NBITS_CNT-1:0] CNT_MAX       = {NBITS_CNT{1'b1}};
   localparam logic [NBITS_RING-1:0] RING_LSB     = NBITS_RING'(1);
   localparam logic [NBITS_RING-1:0] RING_MSB     = RING_LSB << (NBITS_RING - 1);

   function automatic logic [NBITS_RING-1:0] rotl(input logic [NBITS_RING-1:0] x);
      return {x[NBITS_RING-2:0], x[NBITS_RING-1]};
   endfunction

   function automatic logic [NBITS_RING-1:0] rotr(input logic [NBITS_RING-1:0] x);
      return {x[0], x[NBITS_RING-1:1]};
   endfunction

   logic [1:0]            state_q, state_d;
   logic [NBITS_RING-1:0] prev_q, prev_d;
   logic [NBITS_RING-1:0] exp_q, exp_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic [MISS_W-1:0]     miss_q, miss_d, miss_next;
   logic                  dir_q, dir_d, acq_dir;
   logic                  err_pulse_q, err_hit, lap_hit;
   logic [NBITS_CNT-1:0]  lap_q, err_q;

   logic is_legal, is_stall, is_fwd, is_rev, is_match, is_move;
   logic [NBITS_RING-1:0] exp_adv, wrap_val;

   always_comb begin
      is_legal = (din != '0) && ((din & (din - 1'b1)) == '0);
      is_stall = (din == prev_q);
      is_fwd   = (din == rotl(prev_q));
      is_rev   = (din == rotr(prev_q));
      is_match = (din == exp_q);
      exp_adv  = dir_q ? rotr(exp_q) : rotl(exp_q);
      // A lap completes when the matched word is the wrap target of the direction.
      wrap_val = dir_q ? RING_MSB : RING_LSB;
      // First move of an acquisition picks the direction; later moves must follow it.
      acq_dir  = (run_q == '0) ? is_rev : dir_q;
      is_move  = (run_q == '0) ? (is_fwd || is_rev) : (dir_q ? is_rev : is_fwd);
      miss_next = (state_q == ST_LOCKED) ? MISS_W'(1) : miss_q + 1'b1;

      state_d = state_q;
      prev_d  = prev_q;
      exp_d   = exp_q;
      run_d   = run_q;
      miss_d  = miss_q;
      dir_d   = dir_q;
      err_hit = 1'b0;
      lap_hit = 1'b0;

      if (din_valid) begin
         case (state_q)
            ST_SEARCH: begin
               if (is_legal) begin
                  prev_d  = din;
                  run_d   = '0;
                  state_d = ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (!is_legal) begin
                  run_d   = '0;
                  state_d = ST_SEARCH;
               end else if (is_stall) begin
                  // generator hold: nothing to learn
               end else if (is_move) begin
                  prev_d = din;
                  dir_d  = acq_dir;
                  if (run_q + 1'b1 == LOCK_LEN_C) begin
                     run_d   = '0;
                     miss_d  = '0;
                     exp_d   = acq_dir ? rotr(din) : rotl(din);
                     state_d = ST_LOCKED;
                  end else begin
                     run_d = run_q + 1'b1;
                  end
               end else begin
                  prev_d = din;
                  run_d  = '0;
               end
            end
            default: begin // ST_LOCKED, ST_SLIP
               if (is_legal && is_match) begin
                  prev_d  = din;
                  exp_d   = exp_adv;
                  miss_d  = '0;
                  lap_hit = (din == wrap_val);
                  state_d = ST_LOCKED;
               end else if (is_legal && is_stall) begin
                  // hold while locked is not an error
               end else if (is_legal) begin
                  // Flywheel: keep advancing the expectation so a single glitch
                  // re-synchronises on the following sample.
                  err_hit = 1'b1;
                  exp_d   = exp_adv;
                  miss_d  = miss_next;
                  state_d = ST_SLIP;
                  if (miss_next >= UNLOCK_ERRS_C) begin
                     exp_d   = '0;
                     miss_d  = '0;
                     state_d = ST_SEARCH;
                  end
               end else begin
                  err_hit = 1'b1;
                  exp_d   = '0;
                  miss_d  = '0;
                  state_d = ST_SEARCH;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q     <= ST_SEARCH;
         prev_q      <= '0;
         exp_q       <= '0;
         run_q       <= '0;
         miss_q      <= '0;
         dir_q       <= 1'b0;
         err_pulse_q <= 1'b0;
         lap_q       <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         exp_q       <= exp_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         dir_q       <= dir_d;
         err_pulse_q <= err_hit;
         if (clr_counts)
            lap_q <= '0;
         else if (lap_hit && lap_q != CNT_MAX)
            lap_q <= lap_q + 1'b1;
         if (clr_counts)
            err_q <= '0;
         else if (err_hit && err_q != CNT_MAX)
            err_q <= err_q + 1'b1;
      end
   end

   assign state     = state_q;
   assign locked    = state_q[1];
   assign dir       = dir_q;
   assign err_pulse = err_pulse_q;
   assign lap_count = lap_q;
   assign err_count = err_q;
   assign expected  = exp_q;

endmodule

// File: tb/tb_ring_seq_monitor.sv
// Directed bench for ring_seq_monitor. The driver issues one input vector per
// cycle on the falling edge and queues the hand-computed output word for it;
// the monitor pops one entry after every rising edge and compares.
module tb_ring_seq_monitor;

   localparam int W = 25; // {state, locked, dir, err_pulse, lap, err, expected}

   logic       clk_2 = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] din = '0;
   logic       din_valid = 1'b0;
   logic       clr_counts = 1'b0;
   logic       locked, dir, err_pulse;
   logic [7:0] lap_count, err_count;
   logic [3:0] expected;
   logic [1:0] state;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int step_no = 0;

   ring_seq_monitor dut (
      .clk_2(clk_2), .reset(reset), .din(din), .din_valid(din_valid),
      .clr_counts(clr_counts), .locked(locked), .dir(dir), .err_pulse(err_pulse),
      .lap_count(lap_count), .err_count(err_count), .expected(expected), .state(state)
   );

   // clock
   always #5 clk_2 = ~clk_2;

   function automatic logic [W-1:0] pk(input logic [1:0] st, input logic dr, input logic ep,
                                       input logic [7:0] lap, input logic [7:0] err,
                                       input logic [3:0] ex);
      return {st, st[1], dr, ep, lap, err, ex};
   endfunction

   // driver tasks
   task automatic step(input logic v, input logic [3:0] d, input logic c,
                       input logic [1:0] st, input logic dr, input logic ep,
                       input logic [7:0] lap, input logic [7:0] err, input logic [3:0] ex);
      @(negedge clk_2);
      reset      = 1'b0;
      din_valid  = v;
      din        = d;
      clr_counts = c;
      exp_q.push_back(pk(st, dr, ep, lap, err, ex));
   endtask

   task automatic do_reset();
      @(negedge clk_2);
      reset      = 1'b1;
      din_valid  = 1'b1;
      din        = 4'h4;
      clr_counts = 1'b0;
      exp_q.push_back(pk(2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 4'd0));
   endtask

   // scoreboard monitor
   always @(posedge clk_2) begin
      logic [W-1:0] got, want;
      #1;
      if (exp_q.size() != 0) begin
         want = exp_q.pop_front();
         got  = {state, locked, dir, err_pulse, lap_count, err_count, expected};
         step_no++;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL step %0d: got st=%0d lk=%0b dir=%0b ep=%0b lap=%0d err=%0d ex=%h, want st=%0d lk=%0b dir=%0b ep=%0b lap=%0d err=%0d ex=%h",
                     step_no, got[24:23], got[22], got[21], got[20], got[19:12], got[11:4], got[3:0],
                     want[24:23], want[22], want[21], want[20], want[19:12], want[11:4], want[3:0]);
         end
      end
   end

   initial begin
      int eb, ea;
      // forward lock and laps
      do_reset();
      step(1, 4'h1, 0, 1, 0, 0, 0, 0, 4'h0);
      step(1, 4'h2, 0, 1, 0, 0, 0, 0, 4'h0);
      step(1, 4'h4, 0, 1, 0, 0, 0, 0, 4'h0);
      step(1, 4'h8, 0, 1, 0, 0, 0, 0, 4'h0);
      step(1, 4'h1, 0, 2, 0, 0, 0, 0, 4'h2);
      step(1, 4'h2, 0, 2, 0, 0, 0, 0, 4'h4);
      step(1, 4'h4, 0, 2, 0, 0, 0, 0, 4'h8);
      step(1, 4'h8, 0, 2, 0, 0, 0, 0, 4'h1);
      step(1, 4'h1, 0, 2, 0, 0, 1, 0, 4'h2);
      // stall and glitch recovery
      step(1, 4'h2, 0, 2, 0, 0, 1, 0, 4'h4);
      for (int i = 0; i < 3; i++) step(1, 4'h2, 0, 2, 0, 0, 1, 0, 4'h4);
      step(1, 4'h8, 0, 3, 0, 1, 1, 1, 4'h8);
      step(1, 4'h8, 0, 2, 0, 0, 1, 1, 4'h1);
      step(1, 4'h1, 0, 2, 0, 0, 2, 1, 4'h2);
      // loss of lock after two consecutive wrong legal values
      step(1, 4'h4, 0, 3, 0, 1, 2, 2, 4'h4);
      step(1, 4'h8, 0, 0, 0, 1, 2, 3, 4'h0);
      // relock then a zero sample
      step(1, 4'h1, 0, 1, 0, 0, 2, 3, 4'h0);
      step(1, 4'h2, 0, 1, 0, 0, 2, 3, 4'h0);
      step(1, 4'h4, 0, 1, 0, 0, 2, 3, 4'h0);
      step(1, 4'h8, 0, 1, 0, 0, 2, 3, 4'h0);
      step(1, 4'h1, 0, 2, 0, 0, 2, 3, 4'h2);
      step(1, 4'h0, 0, 0, 0, 1, 2, 4, 4'h0);
      // valid gating
      step(0, 4'h5, 0, 0, 0, 0, 2, 4, 4'h0);
      step(0, 4'h1, 0, 0, 0, 0, 2, 4, 4'h0);
      step(1, 4'h1, 0, 1, 0, 0, 2, 4, 4'h0);
      step(0, 4'h2, 0, 1, 0, 0, 2, 4, 4'h0);
      step(0, 4'h0, 0, 1, 0, 0, 2, 4, 4'h0);
      // reverse direction
      do_reset();
      step(1, 4'h8, 0, 1, 0, 0, 0, 0, 4'h0);
      step(1, 4'h4, 0, 1, 1, 0, 0, 0, 4'h0);
      step(1, 4'h2, 0, 1, 1, 0, 0, 0, 4'h0);
      step(1, 4'h1, 0, 1, 1, 0, 0, 0, 4'h0);
      step(1, 4'h8, 0, 2, 1, 0, 0, 0, 4'h4);
      step(1, 4'h4, 0, 2, 1, 0, 0, 0, 4'h2);
      step(1, 4'h2, 0, 2, 1, 0, 0, 0, 4'h1);
      step(1, 4'h1, 0, 2, 1, 0, 0, 0, 4'h8);
      step(1, 4'h8, 0, 2, 1, 0, 1, 0, 4'h4);
      // glitch into SLIP, then reset mid-operation
      step(1, 4'h2, 0, 3, 1, 1, 1, 1, 4'h2);
      do_reset();
      // error counter saturation: lock, then a zero sample, 300 times
      for (int k = 1; k <= 300; k++) begin
         eb = (k - 1 > 255) ? 255 : k - 1;
         ea = (k > 255) ? 255 : k;
         step(1, 4'h1, 0, 1, 0, 0, 0, 8'(eb), 4'h0);
         step(1, 4'h2, 0, 1, 0, 0, 0, 8'(eb), 4'h0);
         step(1, 4'h4, 0, 1, 0, 0, 0, 8'(eb), 4'h0);
         step(1, 4'h8, 0, 1, 0, 0, 0, 8'(eb), 4'h0);
         step(1, 4'h1, 0, 2, 0, 0, 0, 8'(eb), 4'h2);
         step(1, 4'h0, 0, 0, 0, 1, 0, 8'(ea), 4'h0);
      end
      // clear on a cycle that also carries an error
      step(1, 4'h1, 0, 1, 0, 0, 0, 255, 4'h0);
      step(1, 4'h2, 0, 1, 0, 0, 0, 255, 4'h0);
      step(1, 4'h4, 0, 1, 0, 0, 0, 255, 4'h0);
      step(1, 4'h8, 0, 1, 0, 0, 0, 255, 4'h0);
      step(1, 4'h1, 0, 2, 0, 0, 0, 255, 4'h2);
      step(1, 4'h0, 1, 0, 0, 1, 0, 0, 4'h0);
      step(0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0);
      // drain
      repeat (3) @(negedge clk_2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ring_seq_monitor.md
Name: ring_seq_monitor

Overview:
Receive-side checker for the 4-bit one-hot ring-counter pattern (1->2->4->8->1) driven onto LED[7:4] by the lab top-level.
- Samples the ring word, acquires lock on either rotation direction and flywheels through isolated glitches.
- Counts completed laps and sequence errors.
- Outputs feed LCD debug fields and LEDs in the same top-level.

Parameters:
NBITS_RING, 4, width of the one-hot ring word.
NBITS_CNT, 8, width of lap_count and err_count.
LOCK_LEN, 4, consecutive correct transitions needed to declare lock.
UNLOCK_ERRS, 2, consecutive mismatches in SLIP before dropping lock.

Ports:
clk_2  input  1  clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
din  input  NBITS_RING  sampled ring word.
din_valid  input  1  din is evaluated only on cycles where this is 1.
clr_counts  input  1  synchronous clear of lap_count and err_count.
locked  output  1  1 in LOCKED or SLIP.
dir  output  1  0 = forward (rotate-left, 1->2), 1 = reverse (rotate-right, 8->4).
err_pulse  output  1  one-cycle pulse per detected error.
lap_count  output  NBITS_CNT  completed laps while locked; saturating.
err_count  output  NBITS_CNT  errors; saturating.
expected  output  NBITS_RING  next expected ring value (0 when not locked).
state  output  2  SEARCH=0, ACQUIRE=1, LOCKED=2, SLIP=3.

Behaviour:
Clock and reset:
- Clock clk_2; reset synchronous, active-high.
- Reset values: state=SEARCH; locked=0; dir=0; err_pulse=0; lap_count=0; err_count=0; expected=0; internal prev=0, run=0, miss=0.
- Reset mid-operation returns to SEARCH next edge and discards lock.

Latency and sample classes:
- All outputs are registered, reflecting the din_valid sample one cycle later.
- din_valid=0: nothing changes except err_pulse, which returns to 0.
- legal = din has exactly one bit set.
- stall = din==prev.
- fwd = din==rotl(prev).
- rev = din==rotr(prev).

State machine:
- SEARCH: legal -> prev=din, run=0, go ACQUIRE. Illegal samples are ignored and not counted.
- ACQUIRE:
  - stall -> no change.
  - If run==0: fwd sets dir=0, rev sets dir=1, run=1.
  - If run>0: a move in the current dir gives run+1.
  - When run reaches LOCK_LEN, go LOCKED; expected = next value in dir.
  - Legal mismatch -> prev=din, run=0, stay ACQUIRE.
  - Illegal -> SEARCH.
  - No error counting in ACQUIRE.
- LOCKED:
  - Match (din==expected) -> prev=din, expected advances.
  - Lap: a wrap transition, 8->1 when dir=0 or 1->8 when dir=1, increments lap_count.
  - stall -> no change, not an error (covers the generator's load hold).
  - Legal mismatch -> err_pulse=1, err_count+1, miss=1, expected advances by one step (flywheel), go SLIP.
  - Illegal (including 0) -> err_pulse=1, err_count+1, go SEARCH.
- SLIP:
  - Match -> miss=0, prev=din, expected advances, return to LOCKED.
  - A lap transition here also counts.
  - stall -> no change.
  - Legal mismatch -> err_pulse, err_count+1, miss+1, expected advances. If miss reaches UNLOCK_ERRS, go SEARCH.
  - Illegal -> err_pulse, err_count+1, go SEARCH.

Lap rule:
- Laps count only on transitions evaluated while the pre-sample state is LOCKED or SLIP.

Counters:
- Saturate at 2^NBITS_CNT-1; no wrap.
- clr_counts has priority over a same-cycle increment: result is 0.
- err_pulse still asserts on a same-cycle error.

Outputs by state:
- expected=0 and locked=0 in SEARCH/ACQUIRE.
- dir holds its last value.

Test Plan:
- Lock forward: reset, then valid 1,2,4,8,1 -> state=LOCKED and locked=1 on the cycle after the 5th sample. Continuing 2,4,8,1 -> lap_count=1, err_count=0.
- Reverse direction: 8,4,2,1,8 -> locked=1, dir=1. Then 4,2,1,8 -> lap_count=1.
- Stall and glitch recovery:
  - While locked forward at 2, hold 2 for 3 samples -> no error.
  - Then 8 (expected 4) -> err_pulse one cycle, err_count=1, state=SLIP.
  - Then 8 (flywheel expected 8) -> LOCKED, miss=0.
- Loss of lock: locked, two consecutive wrong legal values -> err_count=2, state=SEARCH, locked=0, expected=0. A 0 sample while LOCKED -> err_count+1, SEARCH.
- Saturation and clear:
  - Force 300 errors (NBITS_CNT=8) -> err_count=255.
  - Assert clr_counts on a cycle with an error -> err_count=0, err_pulse=1.
- Mid-operation reset and valid gating:
  - Reset asserted while in SLIP -> all outputs at reset values next cycle.
  - din_valid=0 with changing din -> no state change.
